morse_digit_tx: RTL and testbench

//  Morse transmitter for the digit alphabet: takes ASCII '0'..'9' characters over a valid/ready handshake
//  and drives a key line with standard Morse timing (dot, dash, gaps).

---
 rtl/morse_digit_tx.sv | 140 ++++++++++++++
 tb/tb_morse_digit_tx.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/morse_digit_tx.sv
// Morse transmitter for ASCII digits '0'..'9': accepts one character per
// valid/ready transfer and keys an active-low line with dot/dash/gap timing.
module morse_digit_tx #(
    parameter int UNIT_CYCLES = 25000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] char_in,
    input  logic       char_valid,
    output logic       char_ready,
    output logic       key_n,
    output logic       busy,
    output logic       err
);

    localparam int CW = $clog2(3 * UNIT_CYCLES);
    localparam logic [CW-1:0] UNIT_LEN  = CW'(UNIT_CYCLES - 1);
    localparam logic [CW-1:0] TRIPLE_LEN = CW'(3 * UNIT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MARK  = 2'd1,
        SPACE = 2'd2,
        CGAP  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [4:0]    pat_q, pat_d;
    logic          key_n_q, key_n_d;
    logic          busy_q, busy_d;
    logic          err_q, err_d;

    logic          in_is_digit;
    logic [4:0]    in_pat;

    // Symbol pattern, MSB sent first, 1 = dash.
    always_comb begin
        in_is_digit = (char_in[7:4] == 4'h3) && (char_in[3:0] <= 4'd9);
        case (char_in[3:0])
            4'd1:    in_pat = 5'b01111;
            4'd2:    in_pat = 5'b00111;
            4'd3:    in_pat = 5'b00011;
            4'd4:    in_pat = 5'b00001;
            4'd5:    in_pat = 5'b00000;
            4'd6:    in_pat = 5'b10000;
            4'd7:    in_pat = 5'b11000;
            4'd8:    in_pat = 5'b11100;
            4'd9:    in_pat = 5'b11110;
            default: in_pat = 5'b11111;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        pat_d   = pat_q;
        key_n_d = key_n_q;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (char_valid) begin
                    if (in_is_digit) begin
                        state_d = MARK;
                        pat_d   = in_pat;
                        idx_d   = 3'd0;
                        key_n_d = 1'b0;
                        cnt_d   = in_pat[4] ? TRIPLE_LEN : UNIT_LEN;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            MARK: begin
                if (cnt_q == '0) begin
                    key_n_d = 1'b1;
                    if (idx_q == 3'd4) begin
                        state_d = CGAP;
                        cnt_d   = TRIPLE_LEN;
                    end else begin
                        state_d = SPACE;
                        cnt_d   = UNIT_LEN;
                        idx_d   = idx_q + 3'd1;
                        pat_d   = {pat_q[3:0], 1'b0};
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            SPACE: begin
                if (cnt_q == '0) begin
                    state_d = MARK;
                    key_n_d = 1'b0;
                    cnt_d   = pat_q[4] ? TRIPLE_LEN : UNIT_LEN;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            CGAP: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                    idx_d   = 3'd0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= 3'd0;
            pat_q   <= 5'd0;
            key_n_q <= 1'b1;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            pat_q   <= pat_d;
            key_n_q <= key_n_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    // Ready is the one combinational output so a held request is taken as soon as IDLE is reached.
    assign char_ready = (state_q == IDLE) & ~rst;
    assign key_n      = key_n_q;
    assign busy       = busy_q;
    assign err        = err_q;

endmodule

// File: tb/tb_morse_digit_tx.sv
// Self-checking bench for morse_digit_tx: a per-cycle key-line timeline model
// compared every cycle, plus directed timing checks with hand-computed values.
module tb_morse_digit_tx;

    localparam int U = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] char_in = 8'h30;
    logic       char_valid = 1'b0;
    logic       char_ready;
    logic       key_n;
    logic       busy;
    logic       err;

    int checks = 0;
    int passes = 0;

    morse_digit_tx #(.UNIT_CYCLES(U)) dut (
        .clk        (clk),
        .rst        (rst),
        .char_in    (char_in),
        .char_valid (char_valid),
        .char_ready (char_ready),
        .key_n      (key_n),
        .busy       (busy),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic bit is_digit(input logic [7:0] c);
        return (c >= 8'h30) && (c <= 8'h39);
    endfunction

    // Digits 1..5 start with d dots then dashes; 6..9,0 start with (d-5) dashes then dots.
    function automatic bit sym_is_dash(input int digit, input int i);
        int d;
        d = (digit == 0) ? 10 : digit;
        if (d <= 5) return i >= d;
        return i < d - 5;
    endfunction

    function automatic int frame_len(input int digit);
        int n;
        n = 0;
        for (int i = 0; i < 5; i++) begin
            n += sym_is_dash(digit, i) ? 3 * U : U;
            n += (i < 4) ? U : 3 * U;
        end
        return n;
    endfunction

    // Upcoming key_n values, one per cycle after each clock edge.
    bit key_line[$];

    task automatic push_frame(input int digit);
        for (int i = 0; i < 5; i++) begin
            repeat (sym_is_dash(digit, i) ? 3 * U : U) key_line.push_back(1'b0);
            repeat ((i < 4) ? U : 3 * U) key_line.push_back(1'b1);
        end
    endtask

    // Model + compare process: runs on every cycle for the whole simulation.
    initial begin
        bit r, v, prev_busy, ek, eb, ee;
        logic [7:0] c;
        prev_busy = 1'b0;
        forever begin
            @(posedge clk);
            r = rst;
            v = char_valid;
            c = char_in;
            #1;
            ee = 1'b0;
            if (r) begin
                key_line.delete();
            end else if (v && !prev_busy) begin
                if (is_digit(c)) push_frame(int'(c) - 48);
                else ee = 1'b1;
            end
            if (key_line.size() > 0) begin
                ek = key_line.pop_front();
                eb = 1'b1;
            end else begin
                ek = 1'b1;
                eb = 1'b0;
            end
            check("model_key_n", key_n, ek);
            check("model_busy", busy, eb);
            check("model_err", err, ee);
            check("model_ready", char_ready, !r && !eb);
            prev_busy = eb;
        end
    end

    task automatic send(input logic [7:0] c);
        int n;
        n = 0;
        @(negedge clk);
        char_in = c;
        char_valid = 1'b1;
        while (!char_ready && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("accept_wait_bounded", n < 400, 1);
        @(posedge clk);
    endtask

    // Edges from the accept edge (edge 0) until char_ready is seen high again.
    task automatic wait_ready(output int n);
        n = 0;
        @(negedge clk);
        char_valid = 1'b0;
        while (n < 400) begin
            @(posedge clk);
            n++;
            #1;
            if (char_ready) break;
        end
    endtask

    initial begin
        int n;
        bit acc;

        // Pin the model's frame lengths to hand-counted unit totals.
        check("len_5", frame_len(5), 48);
        check("len_0", frame_len(0), 88);
        check("len_1", frame_len(1), 80);
        check("len_2", frame_len(2), 72);

        repeat (3) @(posedge clk);
        #1;
        check("reset_ready", char_ready, 0);
        check("reset_key_n", key_n, 1);
        check("reset_busy", busy, 0);
        check("reset_err", err, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("ready_after_rst", char_ready, 1);

        send("5"); wait_ready(n); check("frame_5_edges", n, 48);
        send("0"); wait_ready(n); check("frame_0_edges", n, 88);
        send("1"); wait_ready(n); check("frame_1_edges", n, 80);

        send(8'h41);
        #1;
        check("inv_err", err, 1);
        check("inv_key_n", key_n, 1);
        check("inv_ready", char_ready, 1);
        @(negedge clk);
        char_in = "7";
        @(posedge clk);
        #1;
        check("after_inv_key_n", key_n, 0);
        check("after_inv_err", err, 0);
        check("after_inv_busy", busy, 1);
        wait_ready(n); check("frame_7_edges", n, 64);

        // Back-to-back: '2' is 18 units, so the held '3' is taken on edge 72+1.
        send("2");
        n = 0;
        acc = 1'b0;
        @(negedge clk);
        char_in = "3";
        while (!acc && n < 400) begin
            @(posedge clk);
            n++;
            #1;
            if (char_ready) begin
                @(posedge clk);
                n++;
                acc = 1'b1;
            end
        end
        #1;
        check("b2b_accept_edge", n, 73);
        check("b2b_key_n_low", key_n, 0);
        wait_ready(n); check("frame_3_edges", n, 64);

        // Reset in the middle of the second dash of '9' (cycles 16..27).
        send("9");
        @(negedge clk);
        char_valid = 1'b0;
        repeat (19) @(posedge clk);
        @(negedge clk);
        check("nine_dash2_key_n", key_n, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_key_n", key_n, 1);
        check("midrst_busy", busy, 0);
        check("midrst_ready", char_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst_ready_after", char_ready, 1);
        send("5"); wait_ready(n); check("post_rst_frame_5", n, 48);

        // Randomized traffic: digits, stray bytes, changing char_in and rare resets.
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 399) == 0);
            char_valid = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 99) < 85) char_in = 8'h30 + 8'($urandom_range(0, 9));
            else char_in = 8'($urandom_range(0, 255));
        end
        @(negedge clk);
        rst = 1'b0;
        char_valid = 1'b0;
        n = 0;
        while (n < 200) begin
            @(posedge clk);
            n++;
            #1;
            if (char_ready) break;
        end
        check("drain_bounded", n < 200, 1);
        repeat (2) @(posedge clk);
        #1;

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
